// File: rtl/goertzel_multibin_power.sv
// goertzel_multibin_power
// Runs NUM_BINS Goertzel resonators in parallel on one sample stream over blocks of
// 2**SIZE_POW2 samples. At each block end every bin's state is snapshotted and one
// saturated |X|^2 per cycle is drained through a shared 3-stage pipeline.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   start_i, cont_i          begin a block from IDLE; cont_i selects continuous mode
//   stop_i                   abort accumulation / leave continuous mode
//   data_i, valid_i          signed sample stream
//   busy_o                   high while accumulating (FILTER state)
//   valid_o, bin_o, power_o  one power result per bin, single-cycle pulse
//   last_o                   marks the result of bin NUM_BINS-1
//   sat_o                    sticky saturation flag, cleared by an accepted start_i
module goertzel_multibin_power #(
  parameter int unsigned DW         = 16,
  parameter int unsigned NUM_BINS   = 4,
  parameter int unsigned SIZE_POW2  = 8,
  parameter logic [NUM_BINS*SIZE_POW2-1:0] BIN_K = {8'd32, 8'd16, 8'd8, 8'd0},
  parameter int unsigned COEFF_BITS = 24,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 cont_i,
  input  logic                 stop_i,
  input  logic [DW-1:0]        data_i,
  input  logic                 valid_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [(NUM_BINS > 1 ? $clog2(NUM_BINS) : 1)-1:0] bin_o,
  output logic [2*DW-1:0]      power_o,
  output logic                 last_o,
  output logic                 sat_o
);

  localparam int unsigned N  = 2 ** SIZE_POW2;
  localparam int unsigned IW = DW + 2 * SIZE_POW2 + 2;
  localparam int unsigned CF = COEFF_BITS - 3;
  localparam int unsigned BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = 2 * IW + 3;
  localparam real Pi    = 3.14159265358979323846;
  localparam real Scale = 2.0 ** real'(CF);

  typedef logic signed [COEFF_BITS-1:0]    coeff_t;
  typedef logic signed [IW-1:0]            state_t;
  typedef logic signed [IW:0]              ext_t;
  typedef logic signed [COEFF_BITS+IW-1:0] prod_t;
  typedef logic signed [2*IW+1:0]          sq_t;
  typedef enum logic [0:0] {StIdle, StFilter} state_e;

  // Elaboration-time constants, truncated toward zero by $rtoi.
  coeff_t fb_coeff [NUM_BINS];
  coeff_t cos_c    [NUM_BINS];
  coeff_t sin_c    [NUM_BINS];
  for (genvar b = 0; b < NUM_BINS; b++) begin : g_const
    localparam real Theta = 2.0 * Pi * real'(BIN_K[b*SIZE_POW2 +: SIZE_POW2]) / real'(N);
    assign fb_coeff[b] = coeff_t'($rtoi(2.0 * $cos(Theta) * Scale));
    assign cos_c[b]    = coeff_t'($rtoi($cos(Theta) * Scale));
    assign sin_c[b]    = coeff_t'($rtoi($sin(Theta) * Scale));
  end

  state_e state_q, state_d;
  logic   cont_q, cont_d;
  logic   clr_filt, upd, snap_ld, sat_clr;
  logic [SIZE_POW2-1:0] cnt_q;
  state_t s1_q [NUM_BINS];
  state_t s2_q [NUM_BINS];
  state_t snap1_q [NUM_BINS];
  state_t snap2_q [NUM_BINS];
  state_t s0 [NUM_BINS];
  prod_t  fb_prod [NUM_BINS];

  // Resonator update for every bin.
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      fb_prod[b] = prod_t'(fb_coeff[b]) * prod_t'(s1_q[b]);
      s0[b]      = state_t'($signed(data_i)) + state_t'(fb_prod[b] >>> CF) - s2_q[b];
    end
  end

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    clr_filt = 1'b0;
    upd      = 1'b0;
    snap_ld  = 1'b0;
    sat_clr  = 1'b0;
    case (state_q)
      StIdle: begin
        clr_filt = 1'b1;
        if (start_i) begin
          state_d = StFilter;
          cont_d  = cont_i;
          sat_clr = 1'b1;
        end
      end
      StFilter: begin
        // stop_i wins over a simultaneous last sample: the partial block is discarded.
        if (stop_i) begin
          clr_filt = 1'b1;
          state_d  = StIdle;
        end else if (valid_i) begin
          if (&cnt_q) begin
            snap_ld  = 1'b1;
            clr_filt = 1'b1;
            if (!cont_q) state_d = StIdle;
          end else begin
            upd = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      for (int b = 0; b < NUM_BINS; b++) begin
        s1_q[b]    <= '0;
        s2_q[b]    <= '0;
        snap1_q[b] <= '0;
        snap2_q[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      if (clr_filt) begin
        cnt_q <= '0;
        for (int b = 0; b < NUM_BINS; b++) begin
          s1_q[b] <= '0;
          s2_q[b] <= '0;
        end
      end else if (upd) begin
        cnt_q <= cnt_q + 1'b1;
        for (int b = 0; b < NUM_BINS; b++) begin
          s1_q[b] <= s0[b];
          s2_q[b] <= s1_q[b];
        end
      end
      // Snapshot holds the post-update state of the final sample.
      if (snap_ld) begin
        for (int b = 0; b < NUM_BINS; b++) begin
          snap1_q[b] <= s0[b];
          snap2_q[b] <= s1_q[b];
        end
      end
    end
  end

  // Drain sequencer and pipeline.
  logic          drain_q, p1_v_q, p2_v_q;
  logic [BW-1:0] didx_q, p1_bin_q, p2_bin_q;
  ext_t          p1_re_q, p1_im_q, dr_re, dr_im;
  sq_t           p2_re2_q, p2_im2_q;
  prod_t         dr_cprod, dr_sprod;
  logic [SW-1:0] sum;
  logic          sum_sat;
  logic          valid_q, last_q, sat_q;
  logic [BW-1:0] bin_q;
  logic [PW-1:0] power_q;

  always_comb begin
    dr_cprod = prod_t'(cos_c[didx_q]) * prod_t'(snap1_q[didx_q]);
    dr_sprod = prod_t'(sin_c[didx_q]) * prod_t'(snap1_q[didx_q]);
    dr_re    = (ext_t'(dr_cprod >>> CF) - ext_t'(snap2_q[didx_q])) >>> FRAC_BITS;
    dr_im    = ext_t'(dr_sprod >>> CF) >>> FRAC_BITS;
    sum      = SW'($unsigned(p2_re2_q)) + SW'($unsigned(p2_im2_q));
    // Saturated iff anything above the output width is set.
    sum_sat  = |sum[SW-1:PW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q  <= 1'b0;
      didx_q   <= '0;
      p1_v_q   <= 1'b0;
      p1_bin_q <= '0;
      p1_re_q  <= '0;
      p1_im_q  <= '0;
      p2_v_q   <= 1'b0;
      p2_bin_q <= '0;
      p2_re2_q <= '0;
      p2_im2_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      sat_q    <= 1'b0;
      bin_q    <= '0;
      power_q  <= '0;
    end else begin
      if (snap_ld) begin
        drain_q <= 1'b1;
        didx_q  <= '0;
      end else if (drain_q) begin
        didx_q <= didx_q + 1'b1;
        if (didx_q == BW'(NUM_BINS - 1)) drain_q <= 1'b0;
      end
      p1_v_q <= drain_q;
      if (drain_q) begin
        p1_bin_q <= didx_q;
        p1_re_q  <= dr_re;
        p1_im_q  <= dr_im;
      end
      p2_v_q <= p1_v_q;
      if (p1_v_q) begin
        p2_bin_q <= p1_bin_q;
        p2_re2_q <= sq_t'(p1_re_q) * sq_t'(p1_re_q);
        p2_im2_q <= sq_t'(p1_im_q) * sq_t'(p1_im_q);
      end
      valid_q <= p2_v_q;
      last_q  <= p2_v_q && (p2_bin_q == BW'(NUM_BINS - 1));
      if (p2_v_q) begin
        bin_q   <= p2_bin_q;
        power_q <= sum_sat ? '1 : sum[PW-1:0];
      end
      if (p2_v_q && sum_sat) sat_q <= 1'b1;
      else if (sat_clr)      sat_q <= 1'b0;
    end
  end

  assign busy_o  = (state_q == StFilter);
  assign valid_o = valid_q;
  assign bin_o   = bin_q;
  assign power_o = power_q;
  assign last_o  = last_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_goertzel_multibin_power.sv
// Self-checking bench for goertzel_multibin_power. Expected powers come from a floating-point
// DFT of the driven block; a scoreboard queue holds bin, power, tolerance and arrival cycle.
module tb_goertzel_multibin_power;
  localparam int  DW   = 16;
  localparam int  NB   = 4;
  localparam int  N    = 256;
  localparam int  FRAC = 8;
  localparam real Pi   = 3.14159265358979323846;

  typedef struct {
    int     bin;
    longint pwr;
    longint tol;
    longint cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, cont, stop, valid;
  logic [DW-1:0] data;
  logic          busy, vld, last, sat;
  logic [1:0]    bin;
  logic [31:0]   pwr;
  logic          busy_f0, vld_f0, last_f0, sat_f0;
  logic [1:0]    bin_f0;
  logic [31:0]   pwr_f0;

  goertzel_multibin_power dut (
    .clk(clk), .rst(rst), .start_i(start), .cont_i(cont), .stop_i(stop),
    .data_i(data), .valid_i(valid), .busy_o(busy), .valid_o(vld), .bin_o(bin),
    .power_o(pwr), .last_o(last), .sat_o(sat)
  );

  goertzel_multibin_power #(.FRAC_BITS(0)) dut_f0 (
    .clk(clk), .rst(rst), .start_i(start), .cont_i(cont), .stop_i(stop),
    .data_i(data), .valid_i(valid), .busy_o(busy_f0), .valid_o(vld_f0), .bin_o(bin_f0),
    .power_o(pwr_f0), .last_o(last_f0), .sat_o(sat_f0)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_cmp = 0, n_err = 0, n_push = 0, n_vld = 0;
  int     samp [N];
  int     bin_k [NB] = '{0, 8, 16, 32};
  int     mid_start_at = -1;
  longint abs_tol = 9;
  longint last_e;
  exp_t   sb [$];
  exp_t   mon_e;

  task automatic check_val(input string tag, input longint got, input longint exp,
                           input longint tol);
    longint d;
    n_cmp++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic real exp_power(input int k);
    real re, im, w;
    re = 0.0;
    im = 0.0;
    for (int n = 0; n < N; n++) begin
      w  = 2.0 * Pi * real'(k) * real'(n) / real'(N);
      re += real'(samp[n]) * $cos(w);
      im -= real'(samp[n]) * $sin(w);
    end
    return (re * re + im * im) / real'(longint'(1) << (2 * FRAC));
  endfunction

  task automatic fill_dc(input int amp);
    for (int n = 0; n < N; n++) samp[n] = amp;
  endtask

  task automatic fill_cos(input int amp, input int k);
    for (int n = 0; n < N; n++)
      samp[n] = $rtoi(real'(amp) * $cos(2.0 * Pi * real'(k) * real'(n) / real'(N)));
  endtask

  task automatic push_expect();
    exp_t e;
    real  p;
    for (int b = 0; b < NB; b++) begin
      p     = exp_power(bin_k[b]);
      e.bin = b;
      e.pwr = longint'(p);
      e.tol = e.pwr / 100 + abs_tol;
      e.cyc = last_e + 3 + b;
      sb.push_back(e);
      n_push++;
    end
  endtask

  task automatic do_start(input bit c);
    @(negedge clk);
    start = 1'b1;
    cont  = c;
    @(negedge clk);
    start = 1'b0;
    cont  = 1'b0;
    check_val("busy_after_start", busy, 1, 0);
  endtask

  task automatic drive_block(input int nsamp);
    for (int n = 0; n < nsamp; n++) begin
      @(negedge clk);
      data  = DW'(samp[n]);
      valid = 1'b1;
      start = (n == mid_start_at);
      cont  = (n == mid_start_at);
      if (n == N - 1) begin
        last_e = cyc + 1;
        push_expect();
      end
    end
  endtask

  task automatic end_block(input bit exp_busy);
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    check_val("busy_after_last", busy, exp_busy, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check_val("drain_done", sb.size(), 0, 0);
  endtask

  // Scoreboard monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (!rst && vld) begin
      n_vld++;
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 1, 0, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val($sformatf("bin_idx%0d", mon_e.bin), bin, mon_e.bin, 0);
        check_val($sformatf("power_bin%0d", mon_e.bin), pwr, mon_e.pwr, mon_e.tol);
        check_val($sformatf("last_bin%0d", mon_e.bin), last, (mon_e.bin == NB - 1), 0);
        check_val($sformatf("cycle_bin%0d", mon_e.bin), cyc, mon_e.cyc, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  v0;
    bit  got;
    logic [31:0] p_f0;
    logic        s_f0;

    rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0, 0);
    check_val("rst_valid", vld, 0, 0);
    check_val("rst_last", last, 0, 0);
    check_val("rst_sat", sat, 0, 0);
    check_val("rst_bin", bin, 0, 0);
    check_val("rst_power", pwr, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // DC 100, single shot.
    fill_dc(100);
    do_start(1'b0);
    drive_block(N);
    end_block(1'b0);
    wait_drain();

    // Cosine at k=16.
    fill_cos(1000, 16);
    abs_tol = 99;
    do_start(1'b0);
    drive_block(N);
    end_block(1'b0);
    wait_drain();
    abs_tol = 9;
    check_val("sat_clear_cos", sat, 0, 0);

    // Continuous: three back-to-back blocks, then stop.
    fill_dc(100);
    v0 = n_vld;
    do_start(1'b1);
    repeat (3) drive_block(N);
    @(negedge clk);
    valid = 1'b0;
    stop  = 1'b1;
    check_val("busy_cont_after_last", busy, 1, 0);
    @(negedge clk);
    stop = 1'b0;
    check_val("busy_after_stop", busy, 0, 0);
    wait_drain();
    check_val("cont_pulses", n_vld - v0, 12, 0);

    // Abort at sample 100, then a clean block.
    v0 = n_vld;
    do_start(1'b0);
    drive_block(100);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    valid = 1'b0;
    check_val("idle_after_abort", busy, 0, 0);
    repeat (30) @(negedge clk);
    check_val("no_valid_after_abort", n_vld - v0, 0, 0);
    do_start(1'b0);
    drive_block(N);
    end_block(1'b0);
    wait_drain();

    // start_i (with cont_i) mid-block must be ignored.
    mid_start_at = 50;
    do_start(1'b0);
    drive_block(N);
    mid_start_at = -1;
    end_block(1'b0);
    wait_drain();

    // Asynchronous reset in the middle of a drain.
    do_start(1'b0);
    drive_block(N);
    end_block(1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", vld, 0, 0);
    check_val("mid_rst_busy", busy, 0, 0);
    check_val("mid_rst_last", last, 0, 0);
    check_val("mid_rst_bin", bin, 0, 0);
    check_val("mid_rst_power", pwr, 0, 0);
    n_push -= sb.size();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    v0  = n_vld;
    repeat (20) @(negedge clk);
    check_val("no_valid_after_rst", n_vld - v0, 0, 0);

    // Saturation on the FRAC_BITS=0 instance; same stimulus is in range for the default one.
    fill_dc(32767);
    do_start(1'b0);
    check_val("f0_sat_after_start", sat_f0, 0, 0);
    drive_block(N);
    end_block(1'b0);
    got = 1'b0;
    p_f0 = '0;
    s_f0 = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (vld_f0 && bin_f0 == 2'd0) begin
        got  = 1'b1;
        p_f0 = pwr_f0;
        s_f0 = sat_f0;
      end
    end
    check_val("f0_bin0_seen", got, 1, 0);
    check_val("f0_power_sat", p_f0, 64'hFFFF_FFFF, 0);
    check_val("f0_sat_o", s_f0, 1, 0);
    wait_drain();
    check_val("dflt_no_sat", sat, 0, 0);
    repeat (30) @(negedge clk);
    check_val("f0_sat_sticky", sat_f0, 1, 0);
    do_start(1'b0);
    check_val("f0_sat_cleared", sat_f0, 0, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (10) @(negedge clk);

    check_val("total_valid", n_vld, n_push, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
